motor_ramp_ctrl: RTL

//  Upstream command stage for the PWM generator. It drives that generator's ratio, brake and coast inputs.

---
 rtl/motor_pkg.sv | 23 ++
 rtl/ramp_tick_gen.sv | 41 ++++
 rtl/motor_ramp_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/motor_pkg.sv
// ----------------------------------------------------------------------------
// motor_pkg
//   Shared encodings for the motor ramp controller: command opcodes carried on
//   cmd_op and the controller state encoding.
// ----------------------------------------------------------------------------
package motor_pkg;

    typedef enum logic [1:0] {
        OP_RUN   = 2'b00,
        OP_COAST = 2'b01,
        OP_BRAKE = 2'b10,
        OP_RSVD  = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_COAST = 3'd0,
        ST_RAMP  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_DEAD  = 3'd3,
        ST_BRAKE = 3'd4
    } state_e;

endpackage

// File: rtl/ramp_tick_gen.sv
// ----------------------------------------------------------------------------
// ramp_tick_gen
//   Free-running divider that paces the ratio slew. The counter runs
//   0..TICK_DIV-1 and tick is high while it holds TICK_DIV-1.
// Ports
//   clk   in  system clock
//   rst   in  synchronous reset, active-high (counter returns to 0)
//   tick  out one-cycle pulse every TICK_DIV cycles
// ----------------------------------------------------------------------------
module ramp_tick_gen #(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/motor_ramp_ctrl.sv
// ----------------------------------------------------------------------------
// motor_ramp_ctrl
//   Command stage in front of the PWM generator. Accepts RUN/COAST/BRAKE
//   commands over valid/ready, slews ratio toward the target by STEP every
//   ramp tick, and forces a coast dead time before brake is asserted.
//   brake and coast are never high together.
//   Optional watchdog: define MOTOR_RAMP_WDT_EN to force COAST after WDT_CYC
//   cycles without an accepted command while in RAMP or HOLD.
// Ports
//   clk        in  system clock
//   rst        in  synchronous reset, active-high
//   cmd_valid  in  command present
//   cmd_ready  out command can be accepted (low only during dead time)
//   cmd_op     in  00 RUN, 01 COAST, 10 BRAKE, 11 reserved (consumed, no effect)
//   cmd_target in  RUN target ratio
//   ratio      out registered duty ratio
//   brake      out registered brake request
//   coast      out registered coast request
//   at_target  out ratio equals target while in HOLD, COAST or BRAKE
//   wdt_trip   out sticky watchdog flag (0 without MOTOR_RAMP_WDT_EN)
// ----------------------------------------------------------------------------
module motor_ramp_ctrl
    import motor_pkg::*;
#(
    parameter int unsigned W        = 15,
    parameter int unsigned TICK_DIV = 1000,
    parameter int unsigned STEP     = 16,
    parameter int unsigned DEAD_CYC = 64,
    parameter int unsigned WDT_CYC  = 2**20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_target,
    output logic [W-1:0] ratio,
    output logic         brake,
    output logic         coast,
    output logic         at_target,
    output logic         wdt_trip
);

    if (TICK_DIV < 2 || STEP < 1 || DEAD_CYC < 1 || WDT_CYC < 1) begin : g_param_check
        $error("motor_ramp_ctrl: illegal parameter value");
    end

    localparam logic [W:0]  STEP_X    = (W+1)'(STEP);
    localparam int unsigned DC_W      = $clog2(DEAD_CYC + 1);
    localparam logic [DC_W-1:0] DEAD_LAST = DC_W'(DEAD_CYC - 1);

    logic tick;

    ramp_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    state_e          state_q, state_d;
    logic [W-1:0]    ratio_q, ratio_d;
    logic [W-1:0]    tgt_q, tgt_d;
    logic            coast_q, coast_d;
    logic            brake_q, brake_d;
    logic            ready_q, ready_d;
    logic            at_tgt_q, at_tgt_d;
    logic [DC_W-1:0] dead_cnt_q, dead_cnt_d;

    logic            accept;
    cmd_op_e         op;
    logic [W:0]      ratio_x, tgt_x, diff_x;
    logic [W-1:0]    ratio_step;

`ifdef MOTOR_RAMP_WDT_EN
    localparam int unsigned WDT_W = $clog2(WDT_CYC + 1);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYC - 1);

    logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
    logic             wdt_trip_q, wdt_trip_d;

    assign wdt_trip = wdt_trip_q;
`else
    assign wdt_trip = 1'b0;
`endif

    assign accept    = cmd_valid && ready_q;
    assign op        = cmd_op_e'(cmd_op);
    assign cmd_ready = ready_q;
    assign ratio     = ratio_q;
    assign brake     = brake_q;
    assign coast     = coast_q;
    assign at_target = at_tgt_q;

    // One ramp step toward tgt in W+1 bits; a remaining distance of STEP or
    // less lands exactly on tgt, so the result can neither overshoot nor wrap.
    always_comb begin
        ratio_x = {1'b0, ratio_q};
        tgt_x   = {1'b0, tgt_q};
        if (tgt_x >= ratio_x) begin
            diff_x     = tgt_x - ratio_x;
            ratio_step = (diff_x <= STEP_X) ? tgt_q : W'(ratio_x + STEP_X);
        end else begin
            diff_x     = ratio_x - tgt_x;
            ratio_step = (diff_x <= STEP_X) ? tgt_q : W'(ratio_x - STEP_X);
        end
    end

    always_comb begin
        state_d    = state_q;
        ratio_d    = ratio_q;
        tgt_d      = tgt_q;
        dead_cnt_d = dead_cnt_q;
`ifdef MOTOR_RAMP_WDT_EN
        wdt_cnt_d  = wdt_cnt_q;
        wdt_trip_d = wdt_trip_q;
`endif

        case (state_q)
            ST_COAST: begin
                if (accept) begin
                    case (op)
                        OP_RUN: begin
                            if (cmd_target != '0) begin
                                state_d = ST_RAMP;
                                tgt_d   = cmd_target;
                            end
                        end
                        OP_BRAKE: begin
                            state_d    = ST_DEAD;
                            dead_cnt_d = '0;
                        end
                        default: ;
                    endcase
                end
            end

            ST_RAMP, ST_HOLD: begin
                // An accepted command takes priority over a coincident tick.
                if (accept) begin
                    case (op)
                        OP_RUN: begin
                            tgt_d = cmd_target;
                            if (state_q == ST_RAMP || cmd_target != tgt_q) begin
                                state_d = ST_RAMP;
                            end
                        end
                        OP_COAST: begin
                            state_d = ST_COAST;
                        end
                        OP_BRAKE: begin
                            state_d    = ST_DEAD;
                            dead_cnt_d = '0;
                        end
                        default: ;
                    endcase
                end else if (state_q == ST_RAMP && tick) begin
                    ratio_d = ratio_step;
                    if (ratio_step == tgt_q) begin
                        state_d = (tgt_q == '0) ? ST_COAST : ST_HOLD;
                    end
                end
            end

            ST_DEAD: begin
                if (dead_cnt_q == DEAD_LAST) begin
                    state_d = ST_BRAKE;
                end else begin
                    dead_cnt_d = dead_cnt_q + DC_W'(1);
                end
            end

            ST_BRAKE: begin
                if (accept) begin
                    case (op)
                        OP_RUN: begin
                            if (cmd_target != '0) begin
                                state_d = ST_RAMP;
                                tgt_d   = cmd_target;
                            end
                        end
                        OP_COAST: begin
                            state_d = ST_COAST;
                        end
                        default: ;
                    endcase
                end
            end

            default: begin
                state_d = ST_COAST;
            end
        endcase

`ifdef MOTOR_RAMP_WDT_EN
        if (accept) begin
            wdt_cnt_d  = '0;
            wdt_trip_d = 1'b0;
        end else if (state_q == ST_RAMP || state_q == ST_HOLD) begin
            if (wdt_cnt_q == WDT_LAST) begin
                state_d    = ST_COAST;
                wdt_trip_d = 1'b1;
                wdt_cnt_d  = '0;
            end else begin
                wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
            end
        end
`endif

        // Outside RAMP/HOLD the output stage is idle: ratio and target are 0.
        if (state_d == ST_COAST || state_d == ST_DEAD || state_d == ST_BRAKE) begin
            ratio_d = '0;
            tgt_d   = '0;
        end

        coast_d  = (state_d == ST_COAST) || (state_d == ST_DEAD);
        brake_d  = (state_d == ST_BRAKE);
        ready_d  = (state_d != ST_DEAD);
        at_tgt_d = (ratio_d == tgt_d) &&
                   (state_d == ST_HOLD || state_d == ST_COAST || state_d == ST_BRAKE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_COAST;
            ratio_q    <= '0;
            tgt_q      <= '0;
            coast_q    <= 1'b1;
            brake_q    <= 1'b0;
            ready_q    <= 1'b1;
            at_tgt_q   <= 1'b1;
            dead_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ratio_q    <= ratio_d;
            tgt_q      <= tgt_d;
            coast_q    <= coast_d;
            brake_q    <= brake_d;
            ready_q    <= ready_d;
            at_tgt_q   <= at_tgt_d;
            dead_cnt_q <= dead_cnt_d;
        end
    end

`ifdef MOTOR_RAMP_WDT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_cnt_q  <= '0;
            wdt_trip_q <= 1'b0;
        end else begin
            wdt_cnt_q  <= wdt_cnt_d;
            wdt_trip_q <= wdt_trip_d;
        end
    end
`endif

endmodule
